// File: rtl/reversible_pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor built from Peres-gate reversible full adders,
// one operand slice per stage with valid/ready flow control. Optional signed overflow: REV_ADDER_OVF_EN.
module reversible_pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef REV_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Two cascaded Peres gates with the ancilla tied low; returns {carry, sum}.
   // The pass-through outputs of both gates are garbage and are not propagated.
   function automatic logic [1:0] rfa(input logic x, input logic y, input logic c);
      logic p1_q;
      logic p1_r;
      p1_q = x ^ y;
      p1_r = (x & y) ^ 1'b0;
      rfa  = {(p1_q & c) ^ p1_r, p1_q ^ c};
   endfunction

   // Register k holds the state after slice k has been added; register LAST is the output.
   logic             valid_r [STAGES];
   logic [WIDTH-1:0] a_r     [STAGES];
   logic [WIDTH-1:0] b_r     [STAGES];
   logic [WIDTH-1:0] psum_r  [STAGES];
   logic             c_r     [STAGES];

   logic             st_valid_s [STAGES];
   logic [WIDTH-1:0] st_a_s     [STAGES];
   logic [WIDTH-1:0] st_b_s     [STAGES];
   logic [WIDTH-1:0] st_sum_s   [STAGES];
   logic             st_c_s     [STAGES];
   logic [WIDTH-1:0] nxt_sum_s  [STAGES];
   logic             nxt_c_s    [STAGES];
   logic             adv_s;

`ifdef REV_ADDER_OVF_EN
   logic             cmsb_s;
   logic             ovf_r;
`endif

   assign adv_s     = ~valid_r[LAST] | out_ready;
   assign in_ready  = adv_s;
   assign out_valid = valid_r[LAST];
   assign sum       = psum_r[LAST];
   assign cout      = c_r[LAST];
`ifdef REV_ADDER_OVF_EN
   assign ovf       = ovf_r;
`endif

   // Stage inputs: stage 0 takes the conditioned operands, later stages the previous register.
   always_comb begin
      st_valid_s[0] = in_valid;
      st_a_s[0]     = a;
      st_b_s[0]     = b ^ {WIDTH{sub}};
      st_sum_s[0]   = {WIDTH{1'b0}};
      st_c_s[0]     = sub ? 1'b1 : cin;
      for (int k = 1; k < STAGES; k++) begin
         st_valid_s[k] = valid_r[k-1];
         st_a_s[k]     = a_r[k-1];
         st_b_s[k]     = b_r[k-1];
         st_sum_s[k]   = psum_r[k-1];
         st_c_s[k]     = c_r[k-1];
      end
   end

   // Ripple each stage's slice through the reversible cells.
   always_comb begin
      logic       carry_v;
      logic [1:0] cell_v;
`ifdef REV_ADDER_OVF_EN
      cmsb_s = 1'b0;
`endif
      for (int k = 0; k < STAGES; k++) begin
         nxt_sum_s[k] = st_sum_s[k];
         carry_v      = st_c_s[k];
         for (int i = 0; i < SLICE; i++) begin
`ifdef REV_ADDER_OVF_EN
            if ((k * SLICE + i) == (WIDTH - 1)) begin
               cmsb_s = carry_v;
            end else begin
               cmsb_s = cmsb_s;
            end
`endif
            cell_v = rfa(st_a_s[k][k*SLICE+i], st_b_s[k][k*SLICE+i], carry_v);
            nxt_sum_s[k][k*SLICE+i] = cell_v[0];
            carry_v = cell_v[1];
         end
         nxt_c_s[k] = carry_v;
      end
   end

   // Pipeline registers; data only loads behind a valid op so outputs hold across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_r[k] <= 1'b0;
            a_r[k]     <= {WIDTH{1'b0}};
            b_r[k]     <= {WIDTH{1'b0}};
            psum_r[k]  <= {WIDTH{1'b0}};
            c_r[k]     <= 1'b0;
         end
      end else if (adv_s) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_r[k] <= st_valid_s[k];
            if (st_valid_s[k]) begin
               a_r[k]    <= st_a_s[k];
               b_r[k]    <= st_b_s[k];
               psum_r[k] <= nxt_sum_s[k];
               c_r[k]    <= nxt_c_s[k];
            end
         end
      end
   end

`ifdef REV_ADDER_OVF_EN
   // Signed overflow travels with the final stage result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (adv_s && st_valid_s[LAST]) begin
         ovf_r <= cmsb_s ^ nxt_c_s[LAST];
      end
   end
`endif

endmodule
